// File: rtl/sdf_pkg.sv
// sdf_pkg: shared types and helpers for the radix-2 SDF butterfly stage.
//   state_t    : control FSM states
//   clog2      : width of the half-frame counter
//   scale_sat  : halve a widened sum/difference, then clamp to a signed width
// Build option: SDF_BF_ROUND_EN selects round-half-up halving instead of
// truncation. Rounding lets max-minus-min reach 2^(W-1), which the clamp
// folds back to the largest positive code.
package sdf_pkg;

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  // Working width of scale_sat; covers data widths up to 32 bits.
  localparam int SAT_W = 34;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // v is a sign-extended sum or difference; the result fits in 'width' bits.
  function automatic logic signed [SAT_W-1:0] scale_sat(
    input logic signed [SAT_W-1:0] v,
    input int                      width
  );
    logic signed [SAT_W-1:0] s, hi, lo;
`ifdef SDF_BF_ROUND_EN
    s = (v + 34'sd1) >>> 1;
`else
    s = v >>> 1;
`endif
    hi = (34'sd1 <<< (width - 1)) - 34'sd1;
    lo = -hi - 34'sd1;
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/sdf_bf_stage_if.sv
// sdf_bf_stage_if: sample stream, delay-buffer taps and status of one SDF
// butterfly stage.
//   master : environment side (drives samples and the buffer read tap)
//   slave  : the stage (drives the buffer write tap, outputs and err)
interface sdf_bf_stage_if #(
  parameter int WIDTH = 16
);
  logic                    di_en;
  logic signed [WIDTH-1:0] di_re, di_im;
  logic signed [WIDTH-1:0] db_wr_re, db_wr_im;
  logic signed [WIDTH-1:0] db_rd_re, db_rd_im;
  logic                    do_en;
  logic signed [WIDTH-1:0] do_re, do_im;
  logic                    err;

  modport master (
    output di_en, di_re, di_im, db_rd_re, db_rd_im,
    input  db_wr_re, db_wr_im, do_en, do_re, do_im, err
  );

  modport slave (
    input  di_en, di_re, di_im, db_rd_re, db_rd_im,
    output db_wr_re, db_wr_im, do_en, do_re, do_im, err
  );
endinterface

// File: rtl/sdf_bf_arith.sv
// sdf_bf_arith: combinational complex butterfly, a+b and a-b, each halved
// and clamped to WIDTH bits (real and imaginary independent).
//   a_re/a_im : delayed first-half sample
//   b_re/b_im : current second-half sample
//   sum_*     : scale(a+b)
//   dif_*     : scale(a-b)
// Halving mode follows SDF_BF_ROUND_EN through sdf_pkg::scale_sat.
module sdf_bf_arith
  import sdf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic signed [WIDTH-1:0] sum_re,
  output logic signed [WIDTH-1:0] sum_im,
  output logic signed [WIDTH-1:0] dif_re,
  output logic signed [WIDTH-1:0] dif_im
);
  localparam int XW = WIDTH + 2;

  logic signed [XW-1:0] s_re, s_im, d_re, d_im;

  assign s_re = XW'(a_re) + XW'(b_re);
  assign s_im = XW'(a_im) + XW'(b_im);
  assign d_re = XW'(a_re) - XW'(b_re);
  assign d_im = XW'(a_im) - XW'(b_im);

  assign sum_re = WIDTH'(scale_sat(SAT_W'(s_re), WIDTH));
  assign sum_im = WIDTH'(scale_sat(SAT_W'(s_im), WIDTH));
  assign dif_re = WIDTH'(scale_sat(SAT_W'(d_re), WIDTH));
  assign dif_im = WIDTH'(scale_sat(SAT_W'(d_im), WIDTH));
endmodule

// File: rtl/sdf_bf_stage.sv
// sdf_bf_stage: radix-2 single-delay-feedback butterfly stage with control.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : di_* sample in, db_wr_* to the external DEPTH-deep delay
//                    buffer (combinational), db_rd_* from it, do_* registered
//                    output, err sticky protocol-violation flag
// Frames are 2*DEPTH contiguous samples. The first half is parked in the
// buffer; in the second half sums leave directly and halved differences
// go back into the buffer, leaving DEPTH cycles later.
// Build option: SDF_BF_ROUND_EN (rounded halving, see sdf_pkg).
module sdf_bf_stage
  import sdf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  sdf_bf_stage_if.slave  bus
);
  localparam int CNT_W = clog2(DEPTH);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    after_bfly, after_bfly_nxt;
  logic                    en_nxt, err_nxt;
  logic signed [WIDTH-1:0] re_nxt, im_nxt, wr_re, wr_im;
  logic signed [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
  logic                    wrap;

  sdf_bf_arith #(.WIDTH(WIDTH)) u_arith (
    .a_re  (bus.db_rd_re),
    .a_im  (bus.db_rd_im),
    .b_re  (bus.di_re),
    .b_im  (bus.di_im),
    .sum_re(sum_re),
    .sum_im(sum_im),
    .dif_re(dif_re),
    .dif_im(dif_im)
  );

  assign wrap = (cnt == CNT_W'(DEPTH - 1));

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    after_bfly_nxt = after_bfly;
    en_nxt         = 1'b0;
    re_nxt         = '0;
    im_nxt         = '0;
    wr_re          = '0;
    wr_im          = '0;
    err_nxt        = bus.err;
    case (state)
      IDLE: begin
        // The starting sample is FILL slot 0, so it is written right away.
        if (bus.di_en) begin
          wr_re          = bus.di_re;
          wr_im          = bus.di_im;
          state_nxt      = FILL;
          cnt_nxt        = CNT_W'(1);
          after_bfly_nxt = 1'b0;
        end
      end
      FILL: begin
        if (bus.di_en) begin
          wr_re   = bus.di_re;
          wr_im   = bus.di_im;
          en_nxt  = after_bfly;       // previous frame's differences
          re_nxt  = bus.db_rd_re;
          im_nxt  = bus.db_rd_im;
          cnt_nxt = cnt + CNT_W'(1);
          if (wrap) state_nxt = BFLY;
        end else if (after_bfly && cnt == '0) begin
          // The end-of-frame decision is only known the cycle after the
          // last sample: no new sample there means this is drain slot 0.
          en_nxt    = 1'b1;
          re_nxt    = bus.db_rd_re;
          im_nxt    = bus.db_rd_im;
          cnt_nxt   = CNT_W'(1);
          state_nxt = DRAIN;
        end else begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      BFLY: begin
        if (bus.di_en) begin
          wr_re   = dif_re;
          wr_im   = dif_im;
          en_nxt  = 1'b1;
          re_nxt  = sum_re;
          im_nxt  = sum_im;
          cnt_nxt = cnt + CNT_W'(1);
          if (wrap) begin
            state_nxt      = FILL;
            after_bfly_nxt = 1'b1;
          end
        end else begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        en_nxt  = 1'b1;
        re_nxt  = bus.db_rd_re;
        im_nxt  = bus.db_rd_im;
        cnt_nxt = cnt + CNT_W'(1);
        if (bus.di_en) err_nxt = 1'b1;
        if (wrap) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.db_wr_re = wr_re;
  assign bus.db_wr_im = wr_im;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      after_bfly <= 1'b0;
      bus.do_en  <= 1'b0;
      bus.do_re  <= '0;
      bus.do_im  <= '0;
      bus.err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      after_bfly <= after_bfly_nxt;
      bus.do_en  <= en_nxt;
      bus.do_re  <= re_nxt;
      bus.do_im  <= im_nxt;
      bus.err    <= err_nxt;
    end
  end
endmodule

// File: tb/tb_sdf_bf_stage.sv
// tb_sdf_bf_stage: frame-level reference model plus per-cycle compare for
// sdf_bf_stage (DEPTH=4, WIDTH=16) with a behavioural delay buffer attached.
module tb_sdf_bf_stage;
  localparam int D    = 4;
  localparam int W    = 16;
  localparam int MAXC = 4096;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  sdf_bf_stage_if #(.WIDTH(W)) bus ();

  sdf_bf_stage #(.DEPTH(D), .WIDTH(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // external delay buffer: shifts every clock, DEPTH deep
  logic signed [W-1:0] dl_re [D];
  logic signed [W-1:0] dl_im [D];
  always @(posedge clock) begin
    for (int i = D - 1; i > 0; i--) begin
      dl_re[i] <= dl_re[i-1];
      dl_im[i] <= dl_im[i-1];
    end
    dl_re[0] <= bus.db_wr_re;
    dl_im[0] <= bus.db_wr_im;
  end
  assign bus.db_rd_re = dl_re[D-1];
  assign bus.db_rd_im = dl_im[D-1];

  int total = 0;
  int bad   = 0;
  int cap[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  bit ev [MAXC];
  int er [MAXC];
  int ei [MAXC];
  bit err_exp = 1'b0;
  int pos = -1;
  int last_end = -1000;
  int fr_re [2*D];
  int fr_im [2*D];

  function automatic int scl(input int v);
    int s;
`ifdef SDF_BF_ROUND_EN
    s = (v + 1) >>> 1;
`else
    s = v >>> 1;
`endif
    if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
    if (s < -(1 << (W-1)))    s = -(1 << (W-1));
    return s;
  endfunction

  function automatic void sched(input int c, input int re, input int im);
    if (c < MAXC) begin
      ev[c] = 1'b1;
      er[c] = re;
      ei[c] = im;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < MAXC; i++) ev[i] = 1'b0;
    err_exp  = 1'b0;
    pos      = -1;
    last_end = -1000;
  endfunction

  always @(posedge clock) begin
    if (reset_n) begin
      if (pos < 0 && bus.di_en) begin
        // a sample while the last frame's differences are still leaving
        if (cyc >= last_end + 2 && cyc <= last_end + D) err_exp = 1'b1;
        else pos = 0;
      end
      if (pos >= 0) begin
        if (!bus.di_en) begin
          err_exp = 1'b1;
          for (int i = cyc + 1; i <= cyc + 2*D + 2; i++)
            if (i < MAXC) ev[i] = 1'b0;
          pos      = -1;
          last_end = -1000;
        end else begin
          fr_re[pos] = int'(bus.di_re);
          fr_im[pos] = int'(bus.di_im);
          if (pos >= D) begin
            sched(cyc + 1, scl(fr_re[pos-D] + fr_re[pos]), scl(fr_im[pos-D] + fr_im[pos]));
            sched(cyc + 1 + D, scl(fr_re[pos-D] - fr_re[pos]), scl(fr_im[pos-D] - fr_im[pos]));
          end
          pos++;
          if (pos == 2*D) begin
            pos      = -1;
            last_end = cyc;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_do_en", int'(bus.do_en), 0);
      chk("rst_err", int'(bus.err), 0);
    end else if (cyc < MAXC) begin
      chk("do_en", int'(bus.do_en), int'(ev[cyc]));
      if (ev[cyc]) begin
        chk("do_re", int'(bus.do_re), er[cyc]);
        chk("do_im", int'(bus.do_im), ei[cyc]);
      end
      chk("err", int'(bus.err), int'(err_exp));
      if (bus.do_en) cap.push_back(int'(bus.do_re));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit en, input int re, input int im);
    bus.di_en = en;
    bus.di_re = W'(re);
    bus.di_im = W'(im);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int sat_in [8];
    int ramp_exp [8];
    int ab;
    sat_in   = '{32767, -32768, 3, 0, -32768, -32768, 0, 0};
    ramp_exp = '{2, 3, 4, 5, -2, -2, -2, -2};
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;

    // model pins
    chk("scl_trunc", scl(3), `ifdef SDF_BF_ROUND_EN 2 `else 1 `endif);
    chk("scl_satp", scl(32767 + 32768), 32767);
    chk("scl_satn", scl(-65536), -32768);
    chk("scl_neg", scl(-4), -2);

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // 1: ramp frame
    cap.delete();
    for (int i = 0; i < 2*D; i++) tick(1'b1, i, 0);
    idle(D + 4);
    chk("ramp_count", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("ramp_val", cap[i], ramp_exp[i]);
    chk("ramp_idle", int'(dut.state), int'(sdf_pkg::IDLE));

    // 2: back-to-back frames
    cap.delete();
    for (int i = 0; i < 4*D; i++) tick(1'b1, rnd16(), rnd16());
    idle(D + 4);
    chk("b2b_count", cap.size(), 16);

    // 3: saturation / halving corners
    cap.delete();
    for (int i = 0; i < 2*D; i++) tick(1'b1, sat_in[i], sat_in[i]);
    idle(D + 4);
    chk("sat_count", cap.size(), 8);
    if (cap.size() == 8) begin
      chk("sat_sum_min", cap[1], -32768);
      chk("sat_sum_3_0", cap[2], `ifdef SDF_BF_ROUND_EN 2 `else 1 `endif);
      chk("sat_dif_max", cap[4], 32767);
    end

    // 6: stray sample during drain
    cap.delete();
    for (int i = 0; i < 2*D; i++) tick(1'b1, rnd16(), rnd16());
    tick(1'b0, 0, 0);
    tick(1'b1, 123, 45);
    idle(D + 3);
    chk("drain_count", cap.size(), 8);
    chk("drain_err", int'(bus.err), 1);

    // 5: asynchronous reset mid-BFLY
    for (int i = 0; i < D + 2; i++) tick(1'b1, rnd16(), rnd16());
    bus.di_en = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_do_en", int'(bus.do_en), 0);
    chk("arst_do_re", int'(bus.do_re), 0);
    chk("arst_do_im", int'(bus.do_im), 0);
    chk("arst_err", int'(bus.err), 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 2*D; i++) tick(1'b1, rnd16(), rnd16());
    idle(D + 4);

    // 4: gap abort at BFLY slot 2
    for (int i = 0; i < D + 2; i++) tick(1'b1, 10 + i, -i);
    tick(1'b0, 0, 0);
    chk("abort_err", int'(bus.err), 1);
    chk("abort_en", int'(bus.do_en), 0);
    chk("abort_idle", int'(dut.state), int'(sdf_pkg::IDLE));
    idle(3);
    cap.delete();
    for (int i = 0; i < 2*D; i++) tick(1'b1, rnd16(), rnd16());
    idle(D + 4);
    chk("post_abort_count", cap.size(), 8);

    // random frames, gaps, aborts and strays
    for (int f = 0; f < 40; f++) begin
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2*D - 1)) : -1;
      for (int i = 0; i < 2*D; i++) begin
        if (i == ab) begin
          tick(1'b0, 0, 0);
          break;
        end
        tick(1'b1, rnd16(), rnd16());
      end
      repeat ($urandom_range(0, 3)) tick($urandom_range(0, 9) == 0, rnd16(), rnd16());
    end
    idle(2*D + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
